// File: rtl/sw_popcount.sv
// -----------------------------------------------------------------------------
// sw_popcount
//
// Debounced switch bank with popcount / saturating-accumulate display.
//
// Raw switch levels are brought into the clock domain by a two-flop
// synchroniser. The synchronised value must then stay unchanged for
// DEBOUNCE_CYCLES cycles before it is accepted. Every accepted value is
// shown in one of two ways. In popcount mode, o_led shows the number of
// set switches. In accumulate mode, o_led shows a saturating running sum
// of those popcounts. The accumulator is updated in both modes.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_sw     : raw switch levels (asynchronous to i_clk)
//   i_mode   : 0 = show popcount, 1 = show accumulator
//   i_clear  : synchronous accumulator clear
//   o_led    : registered display value
//   o_valid  : one-cycle pulse when o_led first shows a newly accepted value
//   o_sat    : registered flag, high while the accumulator is at full scale
// -----------------------------------------------------------------------------
module sw_popcount #(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACC_W           = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SW-1:0]  i_sw,
    input  logic             i_mode,
    input  logic             i_clear,
    output logic [ACC_W-1:0] o_led,
    output logic             o_valid,
    output logic             o_sat
);

    // A one-cycle debounce still needs a 1-bit counter, which stays at 0.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int POP_W = $clog2(N_SW + 1);

    // The accumulator must be wide enough to hold a single popcount.
    if (ACC_W < POP_W) begin : g_bad_acc_w
        $error("sw_popcount: ACC_W must be at least $clog2(N_SW+1)");
    end

    function automatic logic [ACC_W-1:0] popcnt(input logic [N_SW-1:0] v);
        logic [ACC_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < N_SW; i++) begin
            c = c + ACC_W'(v[i]);
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N_SW-1:0]  sync1_q, sync2_q;
    logic [N_SW-1:0]  cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_SW-1:0]  deb_q,   deb_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic             accept_q, accept_d;
    logic [ACC_W-1:0] led_q,   led_d;
    logic             valid_q, valid_d;
    logic             sat_q,   sat_d;

    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] pop_deb;

    // -------------------------------------------------------------------------
    // Debounce, accumulator and display next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        deb_d    = deb_q;
        acc_d    = acc_q;
        accept_d = 1'b0;

        // One extra carry bit detects overflow of the saturating add.
        acc_sum  = {1'b0, acc_q} + {1'b0, popcnt(cand_q)};
        pop_deb  = popcnt(deb_q);

        if (sync2_q != cand_q) begin
            // Any movement restarts the stability count on the new value.
            cand_d = sync2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Accept only a value that differs from the current one.
            // This prevents a steady input from pulsing o_valid repeatedly.
            if ((cnt_q == CNT_MAX) && (cand_q != deb_q)) begin
                deb_d    = cand_q;
                accept_d = 1'b1;
            end
        end

        if (i_clear) begin
            acc_d = '0;
        end else if (accept_d) begin
            acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end

        // The display stage registers the state present before this edge.
        // This makes it lag deb/acc by one cycle. The accept flag is delayed
        // by the same amount, so o_valid lines up with the new o_led value.
        led_d   = i_mode ? acc_q : pop_deb;
        sat_d   = (acc_q == '1);
        valid_d = accept_q;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            deb_q    <= '0;
            acc_q    <= '0;
            accept_q <= 1'b0;
            led_q    <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            sync1_q  <= i_sw;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            deb_q    <= deb_d;
            acc_q    <= acc_d;
            accept_q <= accept_d;
            led_q    <= led_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
        end
    end

    assign o_led   = led_q;
    assign o_valid = valid_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_sw_popcount.sv
// -----------------------------------------------------------------------------
// tb_sw_popcount
//
// Scoreboard bench for sw_popcount (N_SW=4, DEBOUNCE_CYCLES=4, ACC_W=3).
// Each switch change that should be accepted pushes its expected display,
// saturation flag and arrival edge. Every o_valid pulse pops and checks
// one entry. A pulse that arrives with nothing queued is an error.
// -----------------------------------------------------------------------------
module tb_sw_popcount;

    localparam int N_SW  = 4;
    localparam int DEB   = 4;
    localparam int ACC_W = 3;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk;
    logic             i_rst;
    logic [N_SW-1:0]  i_sw;
    logic             i_mode;
    logic             i_clear;
    logic [ACC_W-1:0] o_led;
    logic             o_valid;
    logic             o_sat;

    sw_popcount #(
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (DEB),
        .ACC_W           (ACC_W)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_sw    (i_sw),
        .i_mode  (i_mode),
        .i_clear (i_clear),
        .o_led   (o_led),
        .o_valid (o_valid),
        .o_sat   (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        int    led;
        int    sat;
        int    due;
        string tag;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Bench-side model of the accepted switch value and the accumulator.
    logic [N_SW-1:0] deb_m = '0;
    int              acc_m = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pop4(input logic [N_SW-1:0] v);
        int c = 0;
        for (int i = 0; i < N_SW; i++) if (v[i]) c++;
        return c;
    endfunction

    // Drive at a falling edge and hold. If the value will be accepted, queue
    // the expected result. That result arrives 8 rising edges after the
    // drive point: 1 for capture, plus 3 + DEB further edges.
    task automatic apply_sw(input logic [N_SW-1:0] v, input int hold,
                            input logic clr_on_accept, input string tag);
        exp_t e;
        if (v != deb_m) begin
            deb_m = v;
            if (clr_on_accept) acc_m = 0;
            else               acc_m = (acc_m + pop4(v) > ACC_MAX) ? ACC_MAX : acc_m + pop4(v);
            e.led = i_mode ? acc_m : pop4(v);
            e.sat = (acc_m == ACC_MAX) ? 1 : 0;
            e.due = edges + 8;
            e.tag = tag;
            sb.push_back(e);
        end
        i_sw = v;
        if (clr_on_accept) begin
            // The accept edge is the 7th rising edge after the drive point.
            repeat (6) @(negedge clk);
            i_clear = 1'b1;
            @(negedge clk);
            i_clear = 1'b0;
            repeat (hold - 7) @(negedge clk);
        end else begin
            repeat (hold) @(negedge clk);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (!i_rst && o_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_led"}, int'(o_led), e.led);
                check({e.tag, "_sat"}, int'(o_sat), e.sat);
                check({e.tag, "_lat"}, edges, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst   = 1'b1;
        i_sw    = '0;
        i_mode  = 1'b0;
        i_clear = 1'b0;

        // Reset state, observed before any clock edge
        #1;
        check("rst_led",   int'(o_led),   0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_sat",   int'(o_sat),   0);
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;

        // Popcount of 1011, then hold steady
        apply_sw(4'b1011, 12, 1'b0, "pop1011");
        check("pop1011_hold_led",   int'(o_led),   3);
        check("pop1011_hold_valid", int'(o_valid), 0);

        // Return to 0, then a two-cycle glitch that must be rejected
        apply_sw(4'b0000, 12, 1'b0, "pop0000");
        i_sw = 4'b0001;
        repeat (2) @(negedge clk);
        i_sw = 4'b0000;
        repeat (12) @(negedge clk);
        check("glitch_led", int'(o_led), 0);

        // Mode switch shows the accumulator one edge later
        i_mode = 1'b1;
        @(negedge clk);
        check("mode1_led", int'(o_led), acc_m);

        // Standalone clear
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        acc_m = 0;
        @(negedge clk);
        check("clear_led", int'(o_led), 0);

        // Accumulate 1, 3, 6
        apply_sw(4'b0001, 10, 1'b0, "acc_a");
        apply_sw(4'b0011, 10, 1'b0, "acc_b");
        apply_sw(4'b0111, 10, 1'b0, "acc_c");

        // Clear on the same edge as an accept, then accept 0001
        apply_sw(4'b0000, 10, 1'b1, "clr_accept");
        apply_sw(4'b0001, 10, 1'b0, "post_clr");

        // Saturation: 4, 4, 7, 7, 7
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        acc_m = 0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            apply_sw((k % 2 == 0) ? 4'b1111 : 4'b0000, 10, 1'b0, "sat_seq");
        end

        // Back to popcount mode: o_led changes, o_sat stays high
        i_mode = 1'b0;
        @(negedge clk);
        check("mode0_led", int'(o_led), 4);
        check("mode0_sat", int'(o_sat), 1);

        // A change during a debounce restarts the count; only 0101 is taken
        i_sw = 4'b0011;
        repeat (3) @(negedge clk);
        apply_sw(4'b0101, 12, 1'b0, "restart");

        // Reset in the middle of debouncing 1111
        i_sw = 4'b1111;
        repeat (3) @(negedge clk);
        #2;
        i_rst = 1'b1;
        i_sw  = '0;
        #1;
        check("midrst_led",   int'(o_led),   0);
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_sat",   int'(o_sat),   0);
        deb_m = '0;
        acc_m = 0;
        @(negedge clk);
        i_rst = 1'b0;
        repeat (20) @(negedge clk);

        // Accept from the first edge after release
        apply_sw(4'b0110, 12, 1'b0, "post_rst");

        repeat (5) @(negedge clk);
        check("sb_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sw_popcount.md
SW_POPCOUNT -- requirements
Module: sw_popcount

Interface
REQ-001 Parameter N_SW, default 4: number of switch inputs, >= 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: cycles a synchronised value must stay stable before it is accepted, >= 1.
REQ-003 Parameter ACC_W, default 8: output and accumulator width, >= $clog2(N_SW+1); elaboration SHALL fail otherwise.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_sw  input  N_SW  raw switch levels, asynchronous to i_clk.
REQ-007 i_mode  input  1  0 = popcount mode, 1 = accumulate mode; synchronous.
REQ-008 i_clear  input  1  synchronous accumulator clear.
REQ-009 o_led  output  ACC_W  registered result.
REQ-010 o_valid  output  1  one-cycle pulse when o_led reflects a newly accepted switch value.
REQ-011 o_sat  output  1  high while the accumulator equals 2^ACC_W-1.

Function
REQ-012 i_sw SHALL pass through a 2-flop synchroniser (s1, s2); s2 is the only version of i_sw used internally.
REQ-013 Debounce state: candidate register cand (N_SW), counter cnt, accepted register deb (N_SW).
REQ-014 Debounce: s2 != cand -> cand <= s2, cnt <= 0; otherwise cnt increments and saturates at DEBOUNCE_CYCLES-1.
REQ-015 Accept: s2 == cand, cnt == DEBOUNCE_CYCLES-1 and cand != deb -> deb <= cand, with a one-cycle internal accept event.
REQ-016 An s2 change that reverts before reaching DEBOUNCE_CYCLES stable cycles SHALL NOT update deb and SHALL NOT pulse o_valid.
REQ-017 pop = number of ones in deb, zero-extended to ACC_W.
REQ-018 Accumulator acc (ACC_W) priority:
- i_clear -> acc <= 0
- else accept event -> acc <= min(acc + popcount(new deb), 2^ACC_W-1)
- else hold
REQ-019 The accumulator SHALL update regardless of i_mode.
REQ-020 o_led SHALL register every cycle: i_mode==0 -> pop; i_mode==1 -> acc. It lags deb/acc by one cycle.
REQ-021 o_valid SHALL be asserted exactly in the cycle o_led first reflects the deb/acc state produced by an accept event.
REQ-022 o_sat SHALL register (acc == 2^ACC_W-1) alongside o_led, independent of i_mode.
REQ-023 Latency: an i_sw change captured at edge k, held stable, SHALL appear on o_led with o_valid=1 after edge k+3+DEBOUNCE_CYCLES.
REQ-024 A new i_sw change during an in-progress debounce SHALL restart the count; only the final stable value is accepted.
REQ-025 i_clear coincident with an accept: acc = 0, the new popcount is not added, and o_valid still pulses.
REQ-026 An i_mode change SHALL take effect on o_led one cycle later without pulsing o_valid.
REQ-027 At saturation, further accepts SHALL hold acc at 2^ACC_W-1; there is no wrap-around.

Reset
REQ-028 i_rst high SHALL immediately clear s1, s2, cand, cnt, deb, acc, o_led, o_valid and o_sat to 0, without waiting for a clock.
REQ-029 Reset asserted mid-debounce SHALL discard the pending candidate; no o_valid pulse for it after release.
REQ-030 After release, a nonzero i_sw held stable SHALL be accepted per REQ-023, counted from the first post-release edge.

Verification (N_SW=4, DEBOUNCE_CYCLES=4, ACC_W=8 unless noted)
REQ-031 Mode 0, reset released, i_sw=4'b1011 held -> o_led=3 with a single o_valid pulse 7 edges after first sample; o_led then stays 3 with o_valid low.
REQ-032 Mode 0, i_sw 0->4'b0001 for 2 cycles then back to 0 -> o_led stays 0, o_valid never asserts.
REQ-033 Mode 1, i_sw sequence 0001, 0011, 0111, each held 10 cycles -> o_led 1, 3, 6, with one o_valid per step.
REQ-034 ACC_W=3, mode 1, i_sw alternating 1111/0000 every 10 cycles -> acc 4, then 7 saturated with o_sat=1, holding 7 on further 1111.
REQ-035 Mode 1, acc=6, i_clear asserted exactly on an accept cycle -> o_led=0, o_valid pulses once; next accept of 0001 gives 1.
REQ-036 i_rst asserted mid-debounce of 4'b1111 -> all outputs 0 without a clock edge; after release with i_sw=0, o_valid stays low.
